// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
// Module      : cpu_ctrl_pkg
// Description : Shared decoder control-bundle layout, opcode constants and
//               small helpers used by the decode/execute pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

    // Control bundle width and bit positions
    localparam int CTRL_W       = 12;
    localparam int REGWRITE     = 0;
    localparam int ALUOP_LO     = 1;
    localparam int ALUOP_HI     = 3;
    localparam int ALUSRC       = 4;
    localparam int REGDST       = 5;
    localparam int BRANCH       = 6;
    localparam int JUMP         = 7;
    localparam int MEMREAD      = 8;
    localparam int MEMWRITE     = 9;
    localparam int MEMTOREG     = 10;
    localparam int JALSEL       = 11;

    typedef logic [CTRL_W-1:0] ctrl_t;

    // Primary opcode values
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // An instruction reads rt unless it is an immediate-source op other than
    // a store, or a jump (which has no register operands at all).
    function automatic logic f_uses_rt(input logic alusrc,
                                       input logic memwrite,
                                       input logic jump);
        return !(alusrc && !memwrite) && !jump;
    endfunction

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_load_use_detect.sv
// ============================================================================
// Module      : load_use_detect
// Description : Combinational load-use hazard detector. Flags the case where
//               the load sitting in EX writes a register the ID instruction
//               reads. A pending flush suppresses the hazard because the ID
//               instruction is being discarded anyway.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_use_detect
    import cpu_ctrl_pkg::*;
#(
    parameter int RADDR_W = 5
) (
    input  logic               ex_mem_read_i,
    input  logic [RADDR_W-1:0] ex_rt_i,
    input  logic [RADDR_W-1:0] id_rs_i,
    input  logic [RADDR_W-1:0] id_rt_i,
    input  logic               id_alusrc_i,
    input  logic               id_memwrite_i,
    input  logic               id_jump_i,
    input  logic               flush_i,
    output logic               hazard_o
);

    logic w_uses_rt;
    logic w_dest_nonzero;
    logic w_rs_match;
    logic w_rt_match;

    // Hazard decision; $0 as load destination never stalls
    always_comb begin
        w_uses_rt      = f_uses_rt(id_alusrc_i, id_memwrite_i, id_jump_i);
        w_dest_nonzero = (ex_rt_i != '0);
        w_rs_match     = (ex_rt_i == id_rs_i);
        w_rt_match     = w_uses_rt && (ex_rt_i == id_rt_i);
        hazard_o       = ex_mem_read_i && w_dest_nonzero
                         && (w_rs_match || w_rt_match) && !flush_i;
    end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with load-use stall insertion and
//               redirect squash. Hazard cycles freeze PC and IF/ID and put a
//               bubble (all-zero control) into EX; flush squashes ID.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage
    import cpu_ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [CTRL_W-1:0]  ctrl_i,
    input  logic [5:0]         funct_i,
    input  logic [DATA_W-1:0]  pc_plus4_i,
    input  logic [DATA_W-1:0]  rs_data_i,
    input  logic [DATA_W-1:0]  rt_data_i,
    input  logic [DATA_W-1:0]  imm_i,
    input  logic [RADDR_W-1:0] rs_i,
    input  logic [RADDR_W-1:0] rt_i,
    input  logic [RADDR_W-1:0] rd_i,
    input  logic               flush_i,
    output logic [CTRL_W-1:0]  ctrl_o,
    output logic [5:0]         funct_o,
    output logic [DATA_W-1:0]  pc_plus4_o,
    output logic [DATA_W-1:0]  rs_data_o,
    output logic [DATA_W-1:0]  rt_data_o,
    output logic [DATA_W-1:0]  imm_o,
    output logic [RADDR_W-1:0] rs_o,
    output logic [RADDR_W-1:0] rt_o,
    output logic [RADDR_W-1:0] rd_o,
    output logic               pc_write_o,
    output logic               ifid_write_o,
    output logic               bubble_o,
    output logic [CNT_W-1:0]   stall_cnt_o
);

    logic [CTRL_W-1:0]  r_ctrl;
    logic [5:0]         r_funct;
    logic [DATA_W-1:0]  r_pc_plus4;
    logic [DATA_W-1:0]  r_rs_data;
    logic [DATA_W-1:0]  r_rt_data;
    logic [DATA_W-1:0]  r_imm;
    logic [RADDR_W-1:0] r_rs;
    logic [RADDR_W-1:0] r_rt;
    logic [RADDR_W-1:0] r_rd;
    logic               r_bubble;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic               w_hazard;

    load_use_detect #(
        .RADDR_W (RADDR_W)
    ) u_load_use_detect (
        .ex_mem_read_i (r_ctrl[MEMREAD]),
        .ex_rt_i       (r_rt),
        .id_rs_i       (rs_i),
        .id_rt_i       (rt_i),
        .id_alusrc_i   (ctrl_i[ALUSRC]),
        .id_memwrite_i (ctrl_i[MEMWRITE]),
        .id_jump_i     (ctrl_i[JUMP]),
        .flush_i       (flush_i),
        .hazard_o      (w_hazard)
    );

    // Pipeline register: data always advances, control is zeroed on squash or stall
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ctrl      <= '0;
            r_funct     <= '0;
            r_pc_plus4  <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rd        <= '0;
            r_bubble    <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_funct    <= funct_i;
            r_pc_plus4 <= pc_plus4_i;
            r_rs_data  <= rs_data_i;
            r_rt_data  <= rt_data_i;
            r_imm      <= imm_i;
            r_rs       <= rs_i;
            r_rt       <= rt_i;
            r_rd       <= rd_i;
            if (flush_i) begin
                r_ctrl   <= '0;
                r_bubble <= 1'b1;
            end else if (w_hazard) begin
                r_ctrl   <= '0;
                r_bubble <= 1'b1;
                // Saturate rather than wrap so the statistic stays monotonic
                if (r_stall_cnt != '1) begin
                    r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                end
            end else begin
                r_ctrl   <= ctrl_i;
                r_bubble <= 1'b0;
            end
        end
    end

    assign ctrl_o       = r_ctrl;
    assign funct_o      = r_funct;
    assign pc_plus4_o   = r_pc_plus4;
    assign rs_data_o    = r_rs_data;
    assign rt_data_o    = r_rt_data;
    assign imm_o        = r_imm;
    assign rs_o         = r_rs;
    assign rt_o         = r_rt;
    assign rd_o         = r_rd;
    assign bubble_o     = r_bubble;
    assign stall_cnt_o  = r_stall_cnt;
    // Hazard already excludes flush, so a redirect always lets PC/IF-ID advance
    assign pc_write_o   = !w_hazard;
    assign ifid_write_o = !w_hazard;

endmodule

`default_nettype wire
